pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer (master) and instruction memory (slave).
// The sequencer presents pc as the fetch address while fetch_req is high.
interface pc_sequencer_if;
  logic        fetch_req;
  logic [31:0] pc;
  logic        instr_valid;
  logic [31:0] instr_rdata;

  modport master (
    output fetch_req,
    output pc,
    input  instr_valid,
    input  instr_rdata
  );

  modport slave (
    input  fetch_req,
    input  pc,
    output instr_valid,
    output instr_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH -> DECODE -> EXECUTE -> UPDATE, with jump/branch redirect.
// Optional feature: define INSTR_COUNT_EN to add the retired_count output.
module pc_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        bus,
  input  logic                  jump,
  input  logic                  beq,
  input  logic                  bne,
  input  logic                  alu_zero,
  input  logic                  stall,
  output logic [5:0]            opcode,
  output logic [31:0]           ir,
  output logic                  branch_taken
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]           retired_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        jump_q, beq_q, bne_q, zero_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic        redirect;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + $unsigned(off);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-PC uses only flags captured in EXECUTE, so UPDATE is immune to input changes.
  always_comb begin
    state_nxt     = state;
    bus.fetch_req = 1'b0;
    pc_plus4      = pc_q + 32'd4;
    redirect      = jump_q | (beq_q & zero_q) | (bne_q & ~zero_q);
    pc_nxt        = pc_plus4;
    if (jump_q)        pc_nxt = jump_target(pc_plus4, ir_q[25:0]);
    else if (redirect) pc_nxt = branch_target(pc_plus4, ir_q[15:0]);
    branch_taken  = 1'b0;
    case (state)
      FETCH: begin
        bus.fetch_req = 1'b1;
        if (!stall && bus.instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (!stall) state_nxt = EXECUTE;
      end
      EXECUTE: begin
        if (!stall) state_nxt = UPDATE;
      end
      UPDATE: begin
        branch_taken = redirect;
        if (!stall) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= 32'd0;
      ir_q   <= 32'd0;
      jump_q <= 1'b0;
      beq_q  <= 1'b0;
      bne_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      if (state == FETCH && bus.instr_valid) ir_q <= bus.instr_rdata;
      if (state == EXECUTE) begin
        jump_q <= jump;
        beq_q  <= beq;
        bne_q  <= bne;
        zero_q <= alu_zero;
      end
      if (state == UPDATE) pc_q <= pc_nxt;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst)                              retired_q <= 32'd0;
    else if (state == UPDATE && !stall)   retired_q <= retired_q + 32'd1;
  end

  assign retired_count = retired_q;
`endif

  assign bus.pc = pc_q;
  assign ir     = ir_q;
  assign opcode = ir_q[31:26];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: sequential, branch, jump, wrap, stall and reset cases.
// Build with INSTR_COUNT_EN defined to also check the retired-instruction counter.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic jump, beq, bne, alu_zero, stall;
  logic [5:0]  opcode;
  logic [31:0] ir;
  logic        branch_taken;
`ifdef INSTR_COUNT_EN
  logic [31:0] retired_count;
`endif
  int total = 0;
  int bad   = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .jump         (jump),
    .beq          (beq),
    .bne          (bne),
    .alu_zero     (alu_zero),
    .stall        (stall),
    .opcode       (opcode),
    .ir           (ir),
    .branch_taken (branch_taken)
`ifdef INSTR_COUNT_EN
    ,
    .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge with the DUT in FETCH.
  task automatic run_instr(input string tag, input logic [31:0] w,
                           input logic j, input logic b, input logic n, input logic z,
                           input int fwait, input int xstall,
                           input logic [31:0] exp_pc, input logic exp_bt, input int exp_cyc);
    logic [31:0] pc0;
    int cyc;
    pc0 = bus.pc;
    cyc = 0;
    for (int i = 0; i < fwait; i++) begin
      bus.instr_valid = 1'b0;
      chk({tag, "_wait_freq"}, {31'd0, bus.fetch_req}, 32'd1);
      chk({tag, "_wait_pc"}, bus.pc, pc0);
      @(negedge clk); cyc++;
    end
    bus.instr_valid = 1'b1;
    bus.instr_rdata = w;
    chk({tag, "_fetch_freq"}, {31'd0, bus.fetch_req}, 32'd1);
    @(negedge clk); cyc++;
    bus.instr_rdata = 32'hDEADBEEF;
    chk({tag, "_dec_freq"}, {31'd0, bus.fetch_req}, 32'd0);
    chk({tag, "_dec_ir"}, ir, w);
    chk({tag, "_dec_opcode"}, {26'd0, opcode}, {26'd0, w[31:26]});
    @(negedge clk); cyc++;
    bus.instr_valid = 1'b0;
    jump = j; beq = b; bne = n; alu_zero = z;
    stall = (xstall > 0);
    chk({tag, "_exe_ir"}, ir, w);
    for (int k = 0; k < xstall; k++) begin
      @(negedge clk); cyc++;
      chk({tag, "_stall_pc"}, bus.pc, pc0);
      chk({tag, "_stall_bt"}, {31'd0, branch_taken}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk); cyc++;
    jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = ~z;
    chk({tag, "_upd_bt"}, {31'd0, branch_taken}, {31'd0, exp_bt});
    chk({tag, "_upd_pc_old"}, bus.pc, pc0);
    chk({tag, "_upd_freq"}, {31'd0, bus.fetch_req}, 32'd0);
    @(negedge clk); cyc++;
    alu_zero = 1'b0;
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_back_freq"}, {31'd0, bus.fetch_req}, 32'd1);
    chk({tag, "_back_bt"}, {31'd0, branch_taken}, 32'd0);
    chk({tag, "_cycles"}, cyc, exp_cyc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_bt", {31'd0, branch_taken}, 32'd0);
    rst = 1'b0;
    chk("post_rst_freq", {31'd0, bus.fetch_req}, 32'd1);
    chk("post_rst_pc", bus.pc, 32'd0);

    run_instr("rtype", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h00000004, 1'b0, 4);
    run_instr("j_to_10", {6'h02, 26'h0000004}, 1, 0, 0, 0, 0, 0, 32'h00000010, 1'b1, 4);
    run_instr("beq_taken", {6'h04, 10'd0, 16'hFFFC}, 0, 1, 0, 1, 0, 0, 32'h00000004, 1'b1, 4);
    run_instr("j_back_10", {6'h02, 26'h0000004}, 1, 0, 0, 0, 0, 0, 32'h00000010, 1'b1, 4);
    run_instr("beq_not", {6'h04, 10'd0, 16'hFFFC}, 0, 1, 0, 0, 0, 0, 32'h00000014, 1'b0, 4);
    run_instr("bne_taken", {6'h05, 10'd0, 16'hFFFE}, 0, 0, 1, 0, 0, 0, 32'h00000010, 1'b1, 4);
    run_instr("bne_not", {6'h05, 10'd0, 16'hFFFE}, 0, 0, 1, 1, 0, 0, 32'h00000014, 1'b0, 4);
    run_instr("unk_stall", 32'hFC000000, 0, 0, 0, 0, 5, 3, 32'h00000018, 1'b0, 12);
    run_instr("j_to_0", {6'h02, 26'h0000000}, 1, 0, 0, 0, 0, 0, 32'h00000000, 1'b1, 4);
    run_instr("beq_to_top", {6'h04, 10'd0, 16'hFFFE}, 0, 1, 0, 1, 0, 0, 32'hFFFFFFFC, 1'b1, 4);
    run_instr("wrap_seq", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h00000000, 1'b0, 4);

    run_instr("chain_j0", {6'h02, 26'h3FFFFFF}, 1, 0, 0, 0, 0, 0, 32'h0FFFFFFC, 1'b1, 4);
    run_instr("chain_s0", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h10000000, 1'b0, 4);
    run_instr("chain_j1", {6'h02, 26'h3FFFFFF}, 1, 0, 0, 0, 0, 0, 32'h1FFFFFFC, 1'b1, 4);
    run_instr("chain_s1", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h20000000, 1'b0, 4);
    run_instr("chain_j2", {6'h02, 26'h3FFFFFF}, 1, 0, 0, 0, 0, 0, 32'h2FFFFFFC, 1'b1, 4);
    run_instr("chain_s2", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h30000000, 1'b0, 4);
    run_instr("chain_j3", {6'h02, 26'h3FFFFFF}, 1, 0, 0, 0, 0, 0, 32'h3FFFFFFC, 1'b1, 4);
    run_instr("chain_s3", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h40000000, 1'b0, 4);
    run_instr("j_4000_0400", {6'h02, 26'h0000100}, 1, 0, 0, 0, 0, 0, 32'h40000400, 1'b1, 4);
    run_instr("j_over_beq", {6'h02, 26'h0000100}, 1, 1, 0, 1, 0, 0, 32'h40000400, 1'b1, 4);

    // Reset arrives in EXECUTE of a taken branch, with stall also high.
    bus.instr_valid = 1'b1;
    bus.instr_rdata = {6'h04, 10'd0, 16'hFFFC};
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    beq = 1'b1; alu_zero = 1'b1; stall = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; beq = 1'b0; alu_zero = 1'b0;
    chk("rstx_pc", bus.pc, 32'd0);
    chk("rstx_freq", {31'd0, bus.fetch_req}, 32'd1);
    chk("rstx_bt", {31'd0, branch_taken}, 32'd0);
    chk("rstx_ir", ir, 32'd0);
`ifdef INSTR_COUNT_EN
    chk("cnt_rst", retired_count, 32'd0);
`endif
    @(negedge clk);
    chk("rstx_hold_pc", bus.pc, 32'd0);
    chk("rstx_hold_bt", {31'd0, branch_taken}, 32'd0);

    // Stall in FETCH must block capture of a valid word.
    stall = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_rdata = 32'h11111111;
    repeat (2) @(negedge clk);
    chk("fstall_freq", {31'd0, bus.fetch_req}, 32'd1);
    chk("fstall_ir", ir, 32'd0);
    chk("fstall_pc", bus.pc, 32'd0);
    stall = 1'b0;

    run_instr("cnt_a", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h00000004, 1'b0, 4);
    run_instr("cnt_b", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h00000008, 1'b0, 4);
    run_instr("cnt_c", 32'h012A4020, 0, 0, 0, 0, 0, 0, 32'h0000000C, 1'b0, 4);
`ifdef INSTR_COUNT_EN
    chk("cnt_three", retired_count, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
